// File: rtl/seg_scan_ctrl_if.sv
// Load channel between the counter/BCD logic and the display scan controller.
// Handshake: the sender drives load_valid with load_data/load_dp held stable
// until a clock edge where load_valid && load_ready are both high; that edge
// transfers the value. load_ready never depends on load_valid.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIG = 4
);
    logic                   load_valid;
    logic                   load_ready;
    logic [4*NUM_DIG-1:0]   load_data;
    logic [NUM_DIG-1:0]     load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. New display values are
// buffered through a one-deep pending register and copied into the shadow
// register only at frame boundaries, so a frame never mixes two values.
module seg_scan_ctrl #(
    parameter int NUM_DIG = 4,
    parameter int DIV     = 4,
    parameter int DEAD    = 1
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_ctrl_if.slave      load_if,
    input  logic                lz_en,
    output logic [7:0]          seg,
    output logic [NUM_DIG-1:0]  dig_en,
    output logic                frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic                   r_pending;
    logic [4*NUM_DIG-1:0]   r_pend_data;
    logic [NUM_DIG-1:0]     r_pend_dp;
    logic [4*NUM_DIG-1:0]   r_shadow_data;
    logic [NUM_DIG-1:0]     r_shadow_dp;
    logic [7:0]             r_seg;
    logic [NUM_DIG-1:0]     r_dig_en;
    logic                   r_frame_done;

    logic                   w_slot_end;
    logic                   w_boundary;
    logic                   w_accept;
    logic                   w_dead;
    logic [3:0]             w_digit;
    logic                   w_dp;
    logic                   w_blank;
    logic                   w_hi_zero;
    logic [7:0]             w_seg_next;
    logic [NUM_DIG-1:0]     w_dig_next;

    // BCD to segments a..g; non-decimal codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
    assign w_accept   = load_if.load_valid && !r_pending;
    assign load_if.load_ready = ~r_pending;

    // Slot counter and digit index; the index steps on the last cycle of a slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending buffer fills on a handshake and drains into the shadow at a frame boundary.
    // Capture and drain are exclusive because capture requires the buffer empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending     <= 1'b0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
        end else if (w_boundary && r_pending) begin
            r_pending     <= 1'b0;
            r_shadow_data <= r_pend_data;
            r_shadow_dp   <= r_pend_dp;
        end else if (w_accept) begin
            r_pending     <= 1'b1;
            r_pend_data   <= load_if.load_data;
            r_pend_dp     <= load_if.load_dp;
        end
    end

    // Select the current digit and decide leading-zero blanking from the digits above it.
    always_comb begin
        w_digit   = '0;
        w_dp      = 1'b0;
        w_blank   = 1'b0;
        w_hi_zero = 1'b1;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (r_idx == IW'(i)) begin
                w_digit = r_shadow_data[4*i +: 4];
                w_dp    = r_shadow_dp[i];
                w_blank = lz_en && (i != 0) && w_hi_zero &&
                          (r_shadow_data[4*i +: 4] == 4'd0);
            end
            if (r_shadow_data[4*i +: 4] != 4'd0) begin
                w_hi_zero = 1'b0;
            end
        end
    end

    assign w_dead     = (int'(r_cnt) < DEAD);
    assign w_seg_next = w_dead ? 8'h00 : {w_dp, (w_blank ? 7'h00 : bcd_to_seg(w_digit))};
    assign w_dig_next = w_dead ? '0 : (NUM_DIG'(1) << r_idx);

    // Register the pin drivers so the display sees glitch-free levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg        <= '0;
            r_dig_en     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dig_en     <= w_dig_next;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign dig_en     = r_dig_en;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: one DUT with DEAD=1 that receives loads, one with
// DEAD=0 that only scans its reset value. Expected display frames are queued
// when stimulus is applied and compared cycle by cycle by the monitors.
module tb_seg_scan_ctrl;
    logic       clk;
    logic       rst;
    logic       lz_en;
    logic       lz0;
    logic [7:0] seg;
    logic [3:0] dig_en;
    logic       frame_done;
    logic [7:0] seg0;
    logic [3:0] dig_en0;
    logic       frame_done0;

    int checks;
    int errors;

    logic [12:0] exp_q[$];
    logic [12:0] exp0_q[$];
    logic [15:0] cur_d;
    logic [3:0]  cur_dp;

    seg_scan_ctrl_if #(.NUM_DIG(4)) ld_if ();
    seg_scan_ctrl_if #(.NUM_DIG(4)) ld0_if ();

    seg_scan_ctrl #(.NUM_DIG(4), .DIV(4), .DEAD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (ld_if),
        .lz_en      (lz_en),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    seg_scan_ctrl #(.NUM_DIG(4), .DIV(4), .DEAD(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .load_if    (ld0_if),
        .lz_en      (lz0),
        .seg        (seg0),
        .dig_en     (dig_en0),
        .frame_done (frame_done0)
    );

    // Clock and static inputs.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] decode_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected {frame_done, dig_en, seg} for output cycle k (0..15) of a frame.
    function automatic logic [12:0] exp_entry(input logic [15:0] d, input logic [3:0] dp,
                                              input logic lz, input int dead, input int k);
        int          idx;
        int          cnt;
        logic        fd;
        logic [3:0]  dg;
        logic [15:0] hi;
        logic        blank;
        logic [6:0]  s;
        idx = k / 4;
        cnt = k % 4;
        fd  = (k == 15);
        if (cnt < dead) return {fd, 4'b0000, 8'h00};
        dg    = d[idx*4 +: 4];
        hi    = d >> (idx * 4);
        blank = lz && (idx != 0) && (hi == 16'h0000);
        s     = blank ? 7'h00 : decode_ref(dg);
        return {fd, 4'(1 << idx), dp[idx], s};
    endfunction

    task automatic push_frames(input int n, input logic lz, input bit with_dead0);
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < 16; k++) begin
                exp_q.push_back(exp_entry(cur_d, cur_dp, lz, 1, k));
                if (with_dead0) exp0_q.push_back(exp_entry(16'h0000, 4'h0, 1'b0, 0, k));
            end
        end
    endtask

    // Scoreboard monitor for the DEAD=1 instance.
    always @(posedge clk) begin
        logic [12:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({frame_done, dig_en, seg} !== e) begin
                errors++;
                $display("FAIL disp_dead1 t=%0t got fd=%b dig=%b seg=%h want fd=%b dig=%b seg=%h",
                         $time, frame_done, dig_en, seg, e[12], e[11:8], e[7:0]);
            end
        end
    end

    // Scoreboard monitor for the DEAD=0 instance.
    always @(posedge clk) begin
        logic [12:0] e;
        #1;
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            checks++;
            if ({frame_done0, dig_en0, seg0} !== e) begin
                errors++;
                $display("FAIL disp_dead0 t=%0t got fd=%b dig=%b seg=%h want fd=%b dig=%b seg=%h",
                         $time, frame_done0, dig_en0, seg0, e[12], e[11:8], e[7:0]);
            end
        end
    end

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_done_timeout got no pulse in 64 cycles want pulse every 16");
        end
    endtask

    task automatic wait_q_empty();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || exp0_q.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout got %0d/%0d entries left want 0", exp_q.size(), exp0_q.size());
            exp_q.delete();
            exp0_q.delete();
        end
    endtask

    // Offer a value, hold it until accepted, then confirm the buffer reads full.
    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        int n;
        n = 0;
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = d;
        ld_if.load_dp    = dp;
        while (ld_if.load_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL load_wait got load_ready=%b after 64 cycles want 1", ld_if.load_ready);
        end
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        checks++;
        if (ld_if.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_accept got %b want 0", ld_if.load_ready);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        lz_en = 1'b0;
        lz0   = 1'b0;
        ld_if.load_valid  = 1'b0;
        ld_if.load_data   = '0;
        ld_if.load_dp     = '0;
        ld0_if.load_valid = 1'b0;
        ld0_if.load_data  = '0;
        ld0_if.load_dp    = '0;
        cur_d  = 16'h0000;
        cur_dp = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame_done, dig_en, seg} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got fd=%b dig=%b seg=%h want all 0", frame_done, dig_en, seg);
        end
        checks++;
        if (ld_if.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ld_if.load_ready);
        end
        checks++;
        if ({frame_done0, dig_en0, seg0} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs0 got fd=%b dig=%b seg=%h want all 0", frame_done0, dig_en0, seg0);
        end
    endtask

    task automatic test_scan();
        push_frames(2, 1'b0, 1'b1);
        rst = 1'b1;
        wait_q_empty();
    endtask

    // Load mid-frame; the current frame keeps the old value, the next shows the new one.
    task automatic test_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        wait_fd();
        lz_en = lz;
        push_frames(1, lz, 1'b0);
        repeat (5) @(negedge clk);
        do_load(d, dp);
        wait_fd();
        checks++;
        if (ld_if.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_frame_done got %b want 1", ld_if.load_ready);
        end
        cur_d  = d;
        cur_dp = dp;
        push_frames(1, lz, 1'b0);
        wait_q_empty();
    endtask

    task automatic test_back_to_back();
        bit seen;
        wait_fd();
        lz_en = 1'b0;
        push_frames(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        do_load(16'h1234, 4'h0);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h00AB;
        ld_if.load_dp    = 4'h0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (ld_if.load_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL early_accept got load_ready=%b want 0 before boundary", ld_if.load_ready);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_boundary got no frame_done want one within 40 cycles");
        end
        checks++;
        if (ld_if.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_at_boundary got %b want 1", ld_if.load_ready);
        end
        cur_d = 16'h1234;
        cur_dp = 4'h0;
        push_frames(1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ld_if.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept got load_ready=%b want 0", ld_if.load_ready);
        end
        ld_if.load_valid = 1'b0;
        wait_fd();
        cur_d = 16'h00AB;
        push_frames(1, 1'b0, 1'b0);
        wait_q_empty();
    endtask

    task automatic test_reset_mid_frame();
        wait_fd();
        do_load(16'h9876, 4'hF);
        repeat (8) @(negedge clk);
        checks++;
        if (dig_en0 !== 4'b0100 || seg0 !== 8'h3F) begin
            errors++;
            $display("FAIL pre_reset_slot0 got dig=%b seg=%h want dig=0100 seg=3f", dig_en0, seg0);
        end
        checks++;
        if (ld_if.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_pending got load_ready=%b want 0", ld_if.load_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({frame_done, dig_en, seg} !== 13'h0 || ld_if.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got fd=%b dig=%b seg=%h ready=%b want 0/0000/00/1",
                     frame_done, dig_en, seg, ld_if.load_ready);
        end
        checks++;
        if ({frame_done0, dig_en0, seg0} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset0 got fd=%b dig=%b seg=%h want all 0", frame_done0, dig_en0, seg0);
        end
        repeat (2) @(negedge clk);
        cur_d  = 16'h0000;
        cur_dp = 4'h0;
        push_frames(2, 1'b0, 1'b1);
        rst = 1'b1;
        wait_q_empty();
    endtask

    // Test sequence and final report.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_scan();
        test_load(16'h1234, 4'h0, 1'b0);
        test_load(16'h0050, 4'h0, 1'b1);
        test_load(16'h0000, 4'h0, 1'b1);
        test_load(16'h0005, 4'b0100, 1'b1);
        test_load(16'h90F7, 4'b1010, 1'b1);
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares a single 8-bit seven-segment bus among NUM_DIG digits of the timer display. It latches new display values through a valid/ready handshake and applies them only at frame boundaries, so the display never tears. Each digit is decoded from BCD, and leading zeros can be blanked. Dead time between digit slots prevents ghosting. It sits between the counter/BCD logic and the physical display pins.

Parameters:
NUM_DIG, 4, number of digits scanned (legal 1..8)
DIV, 4, clk cycles per digit slot (legal >= 2)
DEAD, 1, blank cycles at start of each slot (legal 0..DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
load_valid  in  1  new display value offered
load_ready  out  1  pending buffer empty, can accept
load_data  in  4*NUM_DIG  BCD digits; nibble i = digit i (digit 0 = least significant)
load_dp  in  NUM_DIG  decimal point per digit
lz_en  in  1  leading-zero suppression enable (live, not shadowed)
seg  out  8  bit0..bit6 = segments a..g, bit7 = dp, active-high
dig_en  out  NUM_DIG  one-hot digit enable, active-high
frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, idx=0, pending=0, shadow digits=0, shadow dp=0. seg, dig_en and frame_done are all 0. load_ready is 1.
- Slot counter cnt runs 0..DIV-1 and wraps. When cnt==DIV-1, idx advances 0..NUM_DIG-1 and wraps to 0.
- Frame boundary: cnt==DIV-1 && idx==NUM_DIG-1. Frame period = NUM_DIG*DIV cycles.
- Outputs are registered with 1-cycle latency. At each edge, seg and dig_en load the decode of the pre-edge (cnt, idx, shadow, lz_en) values:
  - cnt < DEAD: dig_en=0, seg=0.
  - Otherwise: dig_en = 1<<idx, seg = {dp[idx], decode(digit[idx])}.
- Decode table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; 10..15 -> 40 (dash).
- Leading-zero blank: applies when lz_en=1, idx!=0, digit[idx]==0, and all digits above idx are 0. Then seg[6:0]=0; dp and dig_en are unaffected. Digit 0 is never blanked.
- load_ready = ~pending (combinational).
- Handshake: load_valid && load_ready at an edge captures load_data/load_dp into the pending buffer and sets pending=1. load_valid while load_ready=0 is ignored; the sender holds its value.
- At a frame-boundary edge with pending=1: shadow <= pending buffer, pending <= 0. The new value shows from the first slot of the next frame.
- Simultaneous capture and boundary with pending=0: the value is captured into pending and applied at the following boundary. There is no bypass.
- frame_done: registered, high for exactly the one cycle after each frame-boundary edge.
- Reset asserted mid-frame: pending data is discarded and all outputs clear immediately. After release, scanning restarts at idx=0, cnt=0.

Test Plan:
(NUM_DIG=4, DIV=4, DEAD=1 unless stated)
1. Release rst, no load -> dig_en sequence 0001,0010,0100,1000, each high 3 of 4 cycles with 0000 in the dead cycle. seg=3F whenever dig_en!=0. frame_done pulses every 16 cycles.
2. load_data=0x1234, load_dp=0, one handshake mid-frame -> load_ready=0 the next cycle. The display is unchanged until the boundary. Next frame shows digit0=66, digit1=4F, digit2=5B, digit3=06. load_ready=1 from the frame_done cycle.
3. lz_en=1, data 0x0050 -> digit3/digit2 seg=00 with dig_en still asserted; digit1=6D, digit0=3F. Data 0x0000 -> only digit0 shows 3F.
4. load_dp=0100 with lz_en=1, data 0x0005 -> digit2 seg=80 (dp only), digit0=6D.
5. Back-to-back: 0x1234 accepted, then 0x00AB held valid while load_ready=0. It is accepted after the boundary, not before. The frame after that shows digit0=40, digit1=40, digit2=3F, digit3=3F.
6. rst low at idx=2 with pending=1 -> seg=00, dig_en=0000, frame_done=0 and load_ready=1 immediately. After release the display shows 3F on all digits; the pending value is never displayed. Repeat with DEAD=0 -> no blank cycle, dig_en held for 4 cycles per slot.
